// File: rtl/rf_cmd_pkg.sv
// Shared command codes and FSM state encodings for the register-file command controller.
package rf_cmd_pkg;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WR_ADDR  = 3'd1;
    localparam state_t ST_WR_DATA  = 3'd2;
    localparam state_t ST_WR_ISSUE = 3'd3;
    localparam state_t ST_RD_ADDR  = 3'd4;
    localparam state_t ST_RD_ISSUE = 3'd5;
    localparam state_t ST_RD_WAIT  = 3'd6;
    localparam state_t ST_TX_WAIT  = 3'd7;

endpackage

// File: rtl/rf_cmd_ctrl.sv
// Decodes 0xAA/0xBB command frames from a byte stream into register-file
// write/read accesses and returns read data as a single TX response byte.
module rf_cmd_ctrl
    import rf_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned REG_WIDTH  = 8,
    parameter int unsigned RD_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_WIDTH-1:0]  RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [REG_WIDTH-1:0]  WrData,
    input  logic [REG_WIDTH-1:0]  RdData,
    input  logic                  RdData_Valid,
    output logic [REG_WIDTH-1:0]  TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr_lat;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [REG_WIDTH-1:0]  r_wr_data;
    logic [REG_WIDTH-1:0]  r_tx_data;
    logic                  r_tx_vld;
    logic                  r_cmd_err;

    logic w_is_wr;
    logic w_is_rd;
    logic w_addr_bad;

    assign w_is_wr    = (RX_P_DATA == REG_WIDTH'(CMD_WR));
    assign w_is_rd    = (RX_P_DATA == REG_WIDTH'(CMD_RD));
    assign w_addr_bad = |(RX_P_DATA >> ADDR_WIDTH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_addr_lat <= '0;
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_address  <= '0;
            r_wr_data  <= '0;
            r_tx_data  <= '0;
            r_tx_vld   <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            // Strobes and the RF address/data bus default to zero; only the
            // transition into an issue state loads them for one cycle.
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_address <= '0;
            r_wr_data <= '0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (RX_D_VLD && w_is_wr)      r_state <= ST_WR_ADDR;
                    else if (RX_D_VLD && w_is_rd) r_state <= ST_RD_ADDR;
                end
                ST_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        if (w_addr_bad) begin
                            r_cmd_err <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_addr_lat <= RX_P_DATA[ADDR_WIDTH-1:0];
                            r_state    <= ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        r_wr_en   <= 1'b1;
                        r_address <= r_addr_lat;
                        r_wr_data <= RX_P_DATA;
                        r_state   <= ST_WR_ISSUE;
                    end
                end
                ST_WR_ISSUE: r_state <= ST_IDLE;
                ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        if (w_addr_bad) begin
                            r_cmd_err <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_rd_en   <= 1'b1;
                            r_address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            r_state   <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    // r_cnt holds the index (1-based) of the wait cycle being sampled
                    r_cnt   <= CNT_W'(1);
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (RdData_Valid) begin
                        r_tx_data <= RdData;
                        r_cnt     <= '0;
                        r_state   <= ST_TX_WAIT;
                    end else if (r_cnt == CNT_W'(RD_TIMEOUT)) begin
                        r_cmd_err <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_TX_WAIT: begin
                    if (!TX_BUSY) begin
                        r_tx_vld <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign WrEn      = r_wr_en;
    assign RdEn      = r_rd_en;
    assign Address   = r_address;
    assign WrData    = r_wr_data;
    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;
    assign CMD_ERR   = r_cmd_err;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Directed self-checking bench for rf_cmd_ctrl: write, read, bad address,
// read timeout, TX backpressure and reset abandonment.
module tb_rf_cmd_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned RW = 8;
    localparam int unsigned TO = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [RW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [RW-1:0] WrData;
    logic [RW-1:0] RdData;
    logic          RdData_Valid;
    logic [RW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          TX_BUSY;
    logic          CMD_ERR;

    int n_cmp = 0;
    int n_mis = 0;

    rf_cmd_ctrl #(
        .ADDR_WIDTH (AW),
        .REG_WIDTH  (RW),
        .RD_TIMEOUT (TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_BUSY      (TX_BUSY),
        .CMD_ERR      (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [RW-1:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        step();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_wren"},  {31'd0, WrEn},     32'd0);
        chk({tag, "_rden"},  {31'd0, RdEn},     32'd0);
        chk({tag, "_addr"},  {28'd0, Address},  32'd0);
        chk({tag, "_wdata"}, {24'd0, WrData},   32'd0);
        chk({tag, "_txvld"}, {31'd0, TX_D_VLD}, 32'd0);
        chk({tag, "_err"},   {31'd0, CMD_ERR},  32'd0);
    endtask

    initial begin
        RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0;
        RdData = '0; RdData_Valid = 1'b0; TX_BUSY = 1'b0;
        step(); step();
        chk_idle_outs("reset");
        chk("reset_txdata", {24'd0, TX_P_DATA}, 32'd0);
        RST = 1'b0;
        step();

        // Write frame AA 07 64
        send(8'hAA);
        send(8'h07);
        chk("wr_early_wren", {31'd0, WrEn}, 32'd0);
        send(8'h64);
        chk("wr_wren",  {31'd0, WrEn},    32'd1);
        chk("wr_addr",  {28'd0, Address}, 32'd7);
        chk("wr_data",  {24'd0, WrData},  32'd100);
        chk("wr_rden",  {31'd0, RdEn},    32'd0);
        step();
        chk_idle_outs("wr_after");

        // Read frame BB 0A, RF answers 0xC8 one cycle after RdEn
        send(8'hBB);
        send(8'h0A);
        chk("rd_rden", {31'd0, RdEn},    32'd1);
        chk("rd_addr", {28'd0, Address}, 32'd10);
        chk("rd_wren", {31'd0, WrEn},    32'd0);
        step();
        chk("rd_rden_once", {31'd0, RdEn}, 32'd0);
        RdData = 8'hC8; RdData_Valid = 1'b1;
        step();
        RdData_Valid = 1'b0; RdData = '0;
        chk("rd_txdata_cap", {24'd0, TX_P_DATA}, 32'd200);
        chk("rd_txvld_pre",  {31'd0, TX_D_VLD},  32'd0);
        step();
        chk("rd_txvld",  {31'd0, TX_D_VLD},  32'd1);
        chk("rd_txdata", {24'd0, TX_P_DATA}, 32'd200);
        step();
        chk("rd_txvld_once", {31'd0, TX_D_VLD},  32'd0);
        chk("rd_txdata_hold", {24'd0, TX_P_DATA}, 32'd200);

        // Bad address (upper nibble set), then a normal read frame
        send(8'hAA);
        send(8'h13);
        chk("bad_err",  {31'd0, CMD_ERR}, 32'd1);
        chk("bad_wren", {31'd0, WrEn},    32'd0);
        step();
        chk("bad_err_once", {31'd0, CMD_ERR}, 32'd0);
        chk("bad_wren2",    {31'd0, WrEn},    32'd0);
        send(8'hBB);
        send(8'h02);
        chk("bad_next_rden", {31'd0, RdEn},    32'd1);
        chk("bad_next_addr", {28'd0, Address}, 32'd2);
        step();
        RdData = 8'h11; RdData_Valid = 1'b1;
        step();
        RdData_Valid = 1'b0;
        step();
        chk("bad_next_txvld",  {31'd0, TX_D_VLD},  32'd1);
        chk("bad_next_txdata", {24'd0, TX_P_DATA}, 32'd17);
        step();

        // Timeout: no RdData_Valid; CMD_ERR exactly TO+1 cycles after RdEn
        send(8'hBB);
        send(8'h03);
        chk("to_rden", {31'd0, RdEn}, 32'd1);
        for (int k = 1; k <= TO; k++) begin
            step();
            chk($sformatf("to_err_c%0d", k), {31'd0, CMD_ERR}, 32'd0);
        end
        step();
        chk("to_err",    {31'd0, CMD_ERR},  32'd1);
        chk("to_txvld",  {31'd0, TX_D_VLD}, 32'd0);
        step();
        chk("to_err_once", {31'd0, CMD_ERR}, 32'd0);

        // Valid in the last wait cycle, then 10 busy cycles with stray bytes
        send(8'hBB);
        send(8'h01);
        TX_BUSY = 1'b1;
        for (int k = 1; k < TO; k++) step();
        step();
        RdData = 8'h5A; RdData_Valid = 1'b1;
        step();
        RdData_Valid = 1'b0; RdData = '0;
        chk("bp_late_err",  {31'd0, CMD_ERR},   32'd0);
        chk("bp_late_data", {24'd0, TX_P_DATA}, 32'd90);
        for (int k = 0; k < 10; k++) begin
            if (k == 3)      RX_P_DATA = 8'hBB;
            else if (k == 9) RX_P_DATA = 8'hAA;
            else             RX_P_DATA = 8'h07;
            RX_D_VLD = (k == 3 || k == 6 || k == 9);
            step();
            chk($sformatf("bp_busy_txvld_%0d", k), {31'd0, TX_D_VLD}, 32'd0);
        end
        RX_D_VLD = 1'b0; RX_P_DATA = '0;
        TX_BUSY = 1'b0;
        step();
        chk("bp_txvld",  {31'd0, TX_D_VLD},  32'd1);
        chk("bp_txdata", {24'd0, TX_P_DATA}, 32'd90);
        step();
        chk("bp_txvld_once", {31'd0, TX_D_VLD}, 32'd0);
        send(8'h07);
        chk("bp_drop_wren1", {31'd0, WrEn}, 32'd0);
        send(8'h64);
        chk("bp_drop_wren2", {31'd0, WrEn}, 32'd0);
        step();
        chk("bp_drop_wren3", {31'd0, WrEn}, 32'd0);

        // Reset between 0xAA and the address byte
        send(8'hAA);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_idle_outs("rst_mid");
        chk("rst_mid_txdata", {24'd0, TX_P_DATA}, 32'd0);
        send(8'h05);
        chk("rst_b1_wren", {31'd0, WrEn}, 32'd0);
        send(8'h64);
        chk("rst_b2_wren", {31'd0, WrEn}, 32'd0);
        step();
        chk("rst_b3_wren", {31'd0, WrEn},    32'd0);
        chk("rst_b3_err",  {31'd0, CMD_ERR}, 32'd0);

        // Reset mid-read, then a late RdData_Valid must be ignored
        send(8'hBB);
        send(8'h04);
        chk("rst_rd_rden", {31'd0, RdEn}, 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        RdData = 8'h77; RdData_Valid = 1'b1;
        step();
        RdData_Valid = 1'b0;
        for (int k = 0; k < TO + 2; k++) begin
            step();
            chk($sformatf("rst_rd_txvld_%0d", k), {31'd0, TX_D_VLD}, 32'd0);
            chk($sformatf("rst_rd_err_%0d", k),   {31'd0, CMD_ERR},  32'd0);
        end
        chk("rst_rd_txdata", {24'd0, TX_P_DATA}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
